// File: rtl/mix_ctrl_pkg.sv
// Shared types and constants for the mixsx32 run controller and its
// payload shifter: state encoding, chu_uart register map, sync byte.
package mix_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BAUD,
        ST_ARM,
        ST_WAIT_MIX,
        ST_CHECK_TX,
        ST_SEND,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [4:0] UART_DVSR_ADDR   = 5'd1;
    localparam logic [4:0] UART_TX_ADDR     = 5'd2;
    localparam int         UART_TX_FULL_BIT = 9;
    localparam logic [7:0] SYNC_BYTE        = 8'hA5;

    // chu_uart takes TX bytes in the low lane of a 32-bit write
    function automatic logic [31:0] tx_word(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/mix_run_ctrl_if.sv
// chu_uart register bus as seen by the run controller.
// master: the controller (drives address/data/strobes, reads status).
// slave:  the UART side.
interface mix_run_ctrl_if;

    logic [4:0]  uart_addr;
    logic [31:0] uart_wr_data;
    logic        uart_write;
    logic        uart_read;
    logic [31:0] uart_rd_data;

    modport master (
        output uart_addr,
        output uart_wr_data,
        output uart_write,
        output uart_read,
        input  uart_rd_data
    );

    modport slave (
        input  uart_addr,
        input  uart_wr_data,
        input  uart_write,
        input  uart_read,
        output uart_rd_data
    );

endinterface

// File: rtl/mix_tx_shifter.sv
// Payload holder for one run: captures the mixer result once, then hands
// out bytes LSB-first, one per advance. Loading also rewinds the byte
// counter, so every run starts from byte 0 regardless of how the previous
// run ended.
module mix_tx_shifter #(
    parameter int NUM_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NUM_BYTES*8-1:0] data_in,
    input  logic                   advance,
    output logic [7:0]             byte_out,
    output logic                   last
);

    localparam int CW = $clog2(NUM_BYTES + 1);

    logic [NUM_BYTES*8-1:0] payload_reg;
    logic [CW-1:0]          count_reg;
    logic [7:0]             byte_lane [NUM_BYTES];

    // Split the payload into byte lanes; lane k is cout[8k +: 8]
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign byte_lane[gi] = payload_reg[gi*8 +: 8];
        end
    endgenerate

    // Capture on load, otherwise step the byte pointer on each send
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_reg <= '0;
            count_reg   <= '0;
        end else if (load) begin
            payload_reg <= data_in;
            count_reg   <= '0;
        end else if (advance) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Select the byte addressed by the counter
    always_comb begin
        byte_out = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (count_reg == CW'(i)) begin
                byte_out = byte_lane[i];
            end
        end
    end

    assign last = (count_reg == CW'(NUM_BYTES - 1));

endmodule

// File: rtl/mix_run_ctrl.sv
// Run sequencer between mixsx32 and chu_uart: programs the baud divisor
// once after reset, releases the mixer, waits for its result under a
// timeout and streams the result bytes into the UART TX FIFO.
// Optional build macro MIX_CTRL_SYNC_BYTE_EN: prefix each payload with a
// 8'hA5 framing byte sent through the same full-flag handshake.
module mix_run_ctrl
    import mix_ctrl_pkg::*;
#(
    parameter  int CWORDS64  = 4,
    parameter  int XWORDS32  = 2,
    parameter  int DVSR      = 651,
    parameter  int TIMEOUT   = 4096,
    localparam int DW        = $clog2(XWORDS32) * CWORDS64,
    localparam int NUM_BYTES = CWORDS64 * 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DW-1:0]         d_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mix_rst,
    output logic [DW-1:0]         mix_d,
    input  logic                  mix_rdy,
    input  logic [CWORDS64*64-1:0] mix_cout,
    mix_run_ctrl_if.master        uart
);

    localparam int TW = $clog2(TIMEOUT);

    state_t          state_reg, state_next;
    logic            baud_done_reg;
    logic            error_reg;
    logic [DW-1:0]   mix_d_reg;
    logic [TW-1:0]   tmo_reg;

    logic            start_accept;
    logic            shift_load;
    logic            shift_advance;
    logic [7:0]      shift_byte;
    logic            shift_last;
    logic [4:0]      tx_addr;
    logic [31:0]     tx_data;
    logic            tx_write;
    logic            tx_full;
    logic            unused_rd_bits;

`ifdef MIX_CTRL_SYNC_BYTE_EN
    logic            sync_pending_reg;
`endif

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign tx_full      = uart.uart_rd_data[UART_TX_FULL_BIT];
    // Only the FIFO-full bit of the status word matters here
    assign unused_rd_bits = ^{uart.uart_rd_data[31:UART_TX_FULL_BIT+1],
                              uart.uart_rd_data[UART_TX_FULL_BIT-1:0]};

    mix_tx_shifter #(
        .NUM_BYTES (NUM_BYTES)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (shift_load),
        .data_in  (mix_cout),
        .advance  (shift_advance),
        .byte_out (shift_byte),
        .last     (shift_last)
    );

    // State register; a reset mid-run drops straight back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and UART write decode
    always_comb begin
        state_next    = state_reg;
        tx_addr       = '0;
        tx_data       = '0;
        tx_write      = 1'b0;
        shift_load    = 1'b0;
        shift_advance = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = baud_done_reg ? ST_ARM : ST_BAUD;
                end
            end
            ST_BAUD: begin
                tx_addr    = UART_DVSR_ADDR;
                tx_data    = 32'(DVSR);
                tx_write   = 1'b1;
                state_next = ST_ARM;
            end
            ST_ARM: begin
                state_next = ST_WAIT_MIX;
            end
            ST_WAIT_MIX: begin
                // a result arriving on the last counted cycle still counts
                if (mix_rdy) begin
                    shift_load = 1'b1;
                    state_next = ST_CHECK_TX;
                end else if (tmo_reg == '0) begin
                    state_next = ST_ERR;
                end
            end
            ST_CHECK_TX: begin
                if (!tx_full) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_addr  = UART_TX_ADDR;
                tx_write = 1'b1;
`ifdef MIX_CTRL_SYNC_BYTE_EN
                if (sync_pending_reg) begin
                    tx_data    = tx_word(SYNC_BYTE);
                    state_next = ST_CHECK_TX;
                end else begin
                    tx_data       = tx_word(shift_byte);
                    shift_advance = 1'b1;
                    state_next    = shift_last ? ST_DONE : ST_CHECK_TX;
                end
`else
                tx_data       = tx_word(shift_byte);
                shift_advance = 1'b1;
                state_next    = shift_last ? ST_DONE : ST_CHECK_TX;
`endif
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Run bookkeeping: baud flag, sticky timeout flag, latched selector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_done_reg <= 1'b0;
            error_reg     <= 1'b0;
            mix_d_reg     <= '0;
        end else begin
            if (state_reg == ST_BAUD) begin
                baud_done_reg <= 1'b1;
            end
            if (start_accept) begin
                error_reg <= 1'b0;
                mix_d_reg <= d_in;
            end else if (state_reg == ST_ERR) begin
                error_reg <= 1'b1;
            end
        end
    end

    // Timeout counter: loaded in ARM, counts down while the mixer is busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_reg <= '0;
        end else if (state_reg == ST_ARM) begin
            tmo_reg <= TW'(TIMEOUT - 1);
        end else if ((state_reg == ST_WAIT_MIX) && !mix_rdy && (tmo_reg != '0)) begin
            tmo_reg <= tmo_reg - 1'b1;
        end
    end

`ifdef MIX_CTRL_SYNC_BYTE_EN
    // Framing byte owed at the start of each run, paid by the first SEND
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pending_reg <= 1'b0;
        end else if (start_accept) begin
            sync_pending_reg <= 1'b1;
        end else if (state_reg == ST_SEND) begin
            sync_pending_reg <= 1'b0;
        end
    end
`endif

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign error   = error_reg;
    assign mix_rst = !((state_reg == ST_ARM) || (state_reg == ST_WAIT_MIX));
    assign mix_d   = mix_d_reg;

    assign uart.uart_addr    = tx_addr;
    assign uart.uart_wr_data = tx_data;
    assign uart.uart_write   = tx_write;
    assign uart.uart_read    = 1'b0;

endmodule

// File: tb/tb_mix_run_ctrl.sv
// Randomized self-checking bench for mix_run_ctrl: a mixer model answers
// after a chosen delay, a UART status model raises the FIFO-full flag at
// random or in a held burst, and every run's write stream is compared with
// the stream the run rules predict.
module tb_mix_run_ctrl;

    localparam int TO    = 16;
    localparam int DV    = 651;
    localparam int NB    = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   d_in;
    logic         busy, done, error, mix_rst;
    logic [3:0]   mix_d;
    logic         mix_rdy;
    logic [255:0] mix_cout;

    mix_run_ctrl_if uart_bus ();

    mix_run_ctrl #(
        .CWORDS64 (4),
        .XWORDS32 (2),
        .DVSR     (DV),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .d_in     (d_in),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .mix_rst  (mix_rst),
        .mix_d    (mix_d),
        .mix_rdy  (mix_rdy),
        .mix_cout (mix_cout),
        .uart     (uart_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation state
    logic [36:0]  wr_q [$];
    int           run_tx_cnt, done_cnt, low_cnt, full_viol, bus_viol;
    logic         full_prev = 1'b0;

    // stimulus models
    int           mix_delay = -1;
    int           mix_cnt   = 0;
    logic [255:0] cap_cout;
    int           full_pct  = 0;
    bit           hold_arm  = 1'b0;
    int           hold_at   = 0;
    int           hold_left = 0;
    bit           baud_model = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // bus monitor, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (uart_bus.uart_write) begin
                wr_q.push_back({uart_bus.uart_addr, uart_bus.uart_wr_data});
                if (uart_bus.uart_addr == 5'd2) begin
                    run_tx_cnt++;
                    if (full_prev) full_viol++;
                end
            end else if (uart_bus.uart_addr != 5'd0 || uart_bus.uart_wr_data != 32'd0) begin
                bus_viol++;
            end
            if (uart_bus.uart_read) bus_viol++;
            if (done) done_cnt++;
            if (!mix_rst) low_cnt++;
            full_prev = uart_bus.uart_rd_data[9];
        end
    end

    // UART status model: random full flag, or a held-full burst
    initial begin
        bit full;
        uart_bus.uart_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (hold_arm && run_tx_cnt >= hold_at) begin
                hold_left = 50;
                hold_arm  = 1'b0;
            end
            if (hold_left > 0) begin
                full = 1'b1;
                hold_left--;
            end else begin
                full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
            end
            uart_bus.uart_rd_data = $urandom;
            uart_bus.uart_rd_data[9] = full;
        end
    end

    // mixer model: data_rdy mix_delay+1 cycles after release, then result churns
    initial begin
        mix_rdy  = 1'b0;
        mix_cout = '0;
        forever begin
            @(posedge clk); #1;
            if (mix_rdy) begin
                mix_rdy  = 1'b0;
                mix_cout = rand256();
            end
            if (!mix_rst) begin
                if (mix_delay >= 0 && mix_cnt == mix_delay + 1) begin
                    mix_rdy  = 1'b1;
                    cap_cout = mix_cout;
                end
                mix_cnt++;
            end else begin
                mix_cnt = 0;
            end
        end
    end

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_busy"},    64'(busy), 64'd0);
        check_val({pfx, "_done"},    64'(done), 64'd0);
        check_val({pfx, "_error"},   64'(error), 64'd0);
        check_val({pfx, "_mix_rst"}, 64'(mix_rst), 64'd1);
        check_val({pfx, "_mix_d"},   64'(mix_d), 64'd0);
        check_val({pfx, "_write"},   64'(uart_bus.uart_write), 64'd0);
        check_val({pfx, "_addr"},    64'(uart_bus.uart_addr), 64'd0);
        check_val({pfx, "_wdata"},   64'(uart_bus.uart_wr_data), 64'd0);
        check_val({pfx, "_read"},    64'(uart_bus.uart_read), 64'd0);
    endtask

    // One run: delay<0 means the mixer never answers; abort_at>=0 resets
    // the block once that many TX writes have been seen.
    task automatic do_run(input logic [3:0] d, input int delay, input int pct,
                          input int hold_byte, input int abort_at);
        logic [36:0] exp_q [$];
        int  lat, guard, n;
        bit  exp_err, first;
        mix_delay = delay;
        full_pct  = pct;
        hold_at   = hold_byte;
        hold_arm  = (hold_byte >= 0);
        mix_cout  = rand256();
        @(posedge clk); #1;
        wr_q.delete();
        run_tx_cnt = 0; done_cnt = 0; low_cnt = 0; full_viol = 0; bus_viol = 0;
        d_in  = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", 64'(busy), 64'd1);
        check_val("error_cleared", 64'(error), 64'd0);
        first = !baud_model;
        lat = 1;
        while (mix_rst && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("start_to_release", 64'(lat), first ? 64'd2 : 64'd1);
        if (first) exp_q.push_back({5'd1, 32'(DV)});
        baud_model = 1'b1;
        exp_err = (delay < 0) || (delay > TO - 1);
        guard = 0;
        while (busy && guard < 3000) begin
            if (abort_at >= 0 && run_tx_cnt == abort_at) begin
                start = 1'b0;
                #1 reset = 1'b1;
                #1;
                check_reset_values("abort");
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
                baud_model = 1'b0;
                $display("run d=%h delay=%0d aborted after %0d tx writes", d, delay, run_tx_cnt);
                return;
            end
            // stray starts and selector changes while busy must be ignored
            start = ($urandom_range(0, 7) == 0);
            d_in  = 4'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        if (guard >= 3000) check_val("busy_never_dropped", 64'd1, 64'd0);
        if (!exp_err) begin
`ifdef MIX_CTRL_SYNC_BYTE_EN
            exp_q.push_back({5'd2, 32'h0000_00A5});
`endif
            for (int k = 0; k < NB; k++) exp_q.push_back({5'd2, 24'd0, cap_cout[8*k +: 8]});
        end
        check_val("write_count", 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (wr_q[i] !== exp_q[i]) begin
                check_val($sformatf("write[%0d]", i), 64'(wr_q[i]), 64'(exp_q[i]));
                break;
            end
        end
        check_val("write_stream_ok", 64'(n), 64'(exp_q.size()));
        check_val("done_pulses", 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        check_val("error_flag", 64'(error), 64'(exp_err));
        check_val("mix_d", 64'(mix_d), 64'(d));
        check_val("write_while_full", 64'(full_viol), 64'd0);
        check_val("idle_bus_nonzero", 64'(bus_viol), 64'd0);
        check_val("mix_release_cycles", 64'(low_cnt), exp_err ? 64'(TO + 1) : 64'(delay + 2));
        $display("run d=%h delay=%0d full%%=%0d writes=%0d error=%0b", d, delay, pct, wr_q.size(), error);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        d_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        do_run(4'b1001, 10, 0, -1, -1);                     // first run, baud write
        do_run(4'($urandom), $urandom_range(0, 12), 0, -1, -1); // no baud write
        do_run(4'($urandom), 5, 0, 5, -1);                   // 50-cycle full hold
        do_run(4'($urandom), -1, 0, -1, -1);                 // timeout
        do_run(4'($urandom), TO - 1, 30, -1, -1);            // rdy on last counted cycle
        do_run(4'($urandom), TO, 0, -1, -1);                 // rdy one cycle too late
        do_run(4'($urandom), 0, 30, -1, -1);                 // immediate result
        do_run(4'hC, 3, 0, -1, 5);                           // reset after 5th byte
        do_run(4'($urandom), 7, 20, -1, -1);                 // baud rewritten
        for (int r = 0; r < 8; r++) begin
            do_run(4'($urandom), $urandom_range(0, TO + 2), $urandom_range(0, 60), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
